// File: rtl/cdb_arbiter.sv
// cdb_arbiter: buffers each execute pipe's results in a private FIFO and round-robin broadcasts them on the CDB
package cdb_pkg;
    typedef logic [31:0] word_t;
    typedef logic [5:0]  rob_id_t;
    typedef struct packed {
        rob_id_t rob_id;
        word_t   w_data;
    } cdb_info_t;
endpackage

module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int SRC_COUNT  = 4,
    parameter int CDB_COUNT  = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int SKID       = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic [SRC_COUNT-1:0] src_valid_i,
    input  cdb_info_t            src_data_i   [SRC_COUNT],
    output logic [SRC_COUNT-1:0] src_ready_o,
    output cdb_info_t            cdb_info_o   [CDB_COUNT],
    output word_t                cdb_data_o   [CDB_COUNT],
    output rob_id_t              cdb_reg_id_o [CDB_COUNT],
    output logic [CDB_COUNT-1:0] cdb_valid_o,
    output logic                 overflow_o
);
    localparam int PW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int SW = SRC_COUNT > 1 ? $clog2(SRC_COUNT) : 1;

    logic [PW-1:0]        r_rd_ptr    [SRC_COUNT];
    logic [PW-1:0]        r_wr_ptr    [SRC_COUNT];
    logic [CW-1:0]        r_count     [SRC_COUNT];
    cdb_info_t            r_mem       [SRC_COUNT][FIFO_DEPTH];
    logic [SW-1:0]        r_rr_ptr;
    cdb_info_t            r_cdb_info  [CDB_COUNT];
    logic [CDB_COUNT-1:0] r_cdb_valid;
    logic [SRC_COUNT-1:0] r_ready;
    logic                 r_overflow;

    logic [SRC_COUNT-1:0] w_grant;
    logic [SW-1:0]        w_port_src  [CDB_COUNT];
    logic [CDB_COUNT-1:0] w_port_vld;
    logic [SW-1:0]        w_rr_next;
    cdb_info_t            w_head      [CDB_COUNT];
    logic [SRC_COUNT-1:0] w_push;
    logic [SRC_COUNT-1:0] w_drop;
    logic [CW-1:0]        w_count_next [SRC_COUNT];

    // Round-robin scan from rr_ptr: first CDB_COUNT non-empty FIFOs win, port n takes the n-th winner
    always_comb begin
        int s;
        int n;
        w_grant   = '0;
        w_port_vld = '0;
        w_rr_next = r_rr_ptr;
        n         = 0;
        s         = 0;
        for (int p = 0; p < CDB_COUNT; p++) w_port_src[p] = '0;
        for (int k = 0; k < SRC_COUNT; k++) begin
            s = int'(r_rr_ptr) + k;
            if (s >= SRC_COUNT) s = s - SRC_COUNT;
            if (r_count[s] != '0 && n < CDB_COUNT) begin
                w_grant[s]    = 1'b1;
                w_port_vld[n] = 1'b1;
                w_port_src[n] = SW'(s);
                w_rr_next     = (s == SRC_COUNT - 1) ? '0 : SW'(s + 1);
                n             = n + 1;
            end
        end
    end

    // Head entry of each granted FIFO, zero on idle ports
    always_comb begin
        for (int p = 0; p < CDB_COUNT; p++)
            w_head[p] = w_port_vld[p] ? r_mem[w_port_src[p]][r_rd_ptr[w_port_src[p]]] : '0;
    end

    // A push into a full FIFO is only accepted when that FIFO pops in the same cycle
    always_comb begin
        for (int i = 0; i < SRC_COUNT; i++) begin
            w_push[i]       = src_valid_i[i] && (r_count[i] != CW'(FIFO_DEPTH) || w_grant[i]);
            w_drop[i]       = src_valid_i[i] && !w_push[i];
            w_count_next[i] = r_count[i] + CW'(w_push[i]) - CW'(w_grant[i]);
        end
    end

    // FIFO storage; contents need no reset since pointers and counts gate visibility
    always_ff @(posedge clk) begin
        for (int i = 0; i < SRC_COUNT; i++)
            if (w_push[i]) r_mem[i][r_wr_ptr[i]] <= src_data_i[i];
    end

    // FIFO pointers, occupancy, ready, round-robin pointer and sticky overflow
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            for (int i = 0; i < SRC_COUNT; i++) begin
                r_rd_ptr[i] <= '0;
                r_wr_ptr[i] <= '0;
                r_count[i]  <= '0;
            end
            r_rr_ptr   <= '0;
            r_ready    <= '1;
            r_overflow <= 1'b0;
        end else begin
            for (int i = 0; i < SRC_COUNT; i++) begin
                if (w_push[i]) r_wr_ptr[i] <= r_wr_ptr[i] + PW'(1);
                if (w_grant[i]) r_rd_ptr[i] <= r_rd_ptr[i] + PW'(1);
                r_count[i] <= w_count_next[i];
                r_ready[i] <= w_count_next[i] <= CW'(FIFO_DEPTH - SKID);
            end
            r_rr_ptr <= w_rr_next;
            if (|w_drop) r_overflow <= 1'b1;
        end
    end

    // Broadcast registers reload every cycle; idle ports carry zero payload
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_cdb_valid <= '0;
            for (int p = 0; p < CDB_COUNT; p++) r_cdb_info[p] <= '0;
        end else begin
            r_cdb_valid <= w_port_vld;
            for (int p = 0; p < CDB_COUNT; p++) r_cdb_info[p] <= w_head[p];
        end
    end

    for (genvar k = 0; k < CDB_COUNT; k++) begin : g_port
        assign cdb_info_o[k]   = r_cdb_info[k];
        assign cdb_data_o[k]   = r_cdb_info[k].w_data;
        assign cdb_reg_id_o[k] = r_cdb_info[k].rob_id;
    end

    assign cdb_valid_o = r_cdb_valid;
    assign src_ready_o = r_ready;
    assign overflow_o  = r_overflow;
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed scenarios scored against a queue-based reference of the CDB arbiter
module tb_cdb_arbiter;
    import cdb_pkg::*;

    logic      clk;
    logic      rst_n;
    logic      flush;
    logic [3:0] src_valid_i;
    cdb_info_t src_data_i   [4];
    logic [3:0] src_ready_o;
    cdb_info_t cdb_info_o   [2];
    word_t     cdb_data_o   [2];
    rob_id_t   cdb_reg_id_o [2];
    logic [1:0] cdb_valid_o;
    logic      overflow_o;

    cdb_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .src_valid_i  (src_valid_i),
        .src_data_i   (src_data_i),
        .src_ready_o  (src_ready_o),
        .cdb_info_o   (cdb_info_o),
        .cdb_data_o   (cdb_data_o),
        .cdb_reg_id_o (cdb_reg_id_o),
        .cdb_valid_o  (cdb_valid_o),
        .overflow_o   (overflow_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    cdb_info_t  mq [4][$];
    int         m_rr;
    logic [1:0] e_vld;
    cdb_info_t  e_info [2];
    logic [3:0] e_rdy;
    logic       e_ovf;

    int sq   [4];
    int mark [4];
    int bc   [4];
    int stale;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic cdb_info_t mk(input int s, input int id);
        cdb_info_t r;
        r.rob_id = rob_id_t'(id);
        r.w_data = word_t'(s * 65536 + id);
        return r;
    endfunction

    function automatic logic [3:0] m_grants();
        logic [3:0] g;
        int n;
        int s;
        g = '0;
        n = 0;
        for (int k = 0; k < 4; k++) begin
            s = (m_rr + k) % 4;
            if (mq[s].size() != 0 && n < 2) begin
                g[s] = 1'b1;
                n++;
            end
        end
        return g;
    endfunction

    task automatic model_edge();
        logic [3:0] g;
        int p;
        int last;
        int s;
        if (!rst_n || flush) begin
            for (int i = 0; i < 4; i++) mq[i].delete();
            m_rr = 0;
            e_vld = '0;
            e_info[0] = '0;
            e_info[1] = '0;
            e_rdy = 4'hf;
            e_ovf = 1'b0;
        end else begin
            g = m_grants();
            p = 0;
            last = 0;
            e_vld = '0;
            e_info[0] = '0;
            e_info[1] = '0;
            for (int k = 0; k < 4; k++) begin
                s = (m_rr + k) % 4;
                if (g[s]) begin
                    e_info[p] = mq[s].pop_front();
                    e_vld[p] = 1'b1;
                    last = s;
                    p++;
                end
            end
            if (p > 0) m_rr = (last + 1) % 4;
            for (int i = 0; i < 4; i++)
                if (src_valid_i[i]) begin
                    if (mq[i].size() < 4) mq[i].push_back(src_data_i[i]);
                    else e_ovf = 1'b1;
                end
            for (int i = 0; i < 4; i++) e_rdy[i] = mq[i].size() <= 2;
        end
    endtask

    task automatic step(input logic [3:0] v, input logic fl);
        int src;
        for (int s = 0; s < 4; s++) begin
            src_valid_i[s] = v[s];
            src_data_i[s]  = v[s] ? mk(s, sq[s]) : '0;
            if (v[s]) sq[s]++;
        end
        flush = fl;
        @(posedge clk);
        model_edge();
        #1;
        chk("cdb_valid", 64'(cdb_valid_o), 64'(e_vld));
        for (int p = 0; p < 2; p++) begin
            chk("cdb_info", 64'(cdb_info_o[p]), 64'(e_info[p]));
            chk("cdb_reg_id", 64'(cdb_reg_id_o[p]), 64'(e_info[p].rob_id));
            chk("cdb_data", 64'(cdb_data_o[p]), 64'(e_info[p].w_data));
        end
        chk("src_ready", 64'(src_ready_o), 64'(e_rdy));
        chk("overflow", 64'(overflow_o), 64'(e_ovf));
        for (int p = 0; p < 2; p++)
            if (cdb_valid_o[p] === 1'b1) begin
                src = int'(cdb_info_o[p].w_data[17:16]);
                bc[src]++;
                if (int'(cdb_info_o[p].w_data[15:0]) < mark[src]) stale++;
            end
        src_valid_i = '0;
        flush = 1'b0;
    endtask

    initial begin
        logic [3:0] v;
        logic [3:0] r_prev;
        logic [3:0] g;
        int pushed [4];
        int mx;
        int mn;
        int exp_wrap;
        logic seen_low;
        logic done_acc;
        logic done_drop;

        rst_n = 1'b0;
        flush = 1'b0;
        src_valid_i = '0;
        for (int s = 0; s < 4; s++) begin
            src_data_i[s] = '0;
            sq[s] = 0;
            mark[s] = 0;
            bc[s] = 0;
            pushed[s] = 0;
        end
        stale = 0;
        #2;

        // reset and single-push latency
        step(4'b0000, 1'b0);
        step(4'b0000, 1'b0);
        chk("rst_valid", 64'(cdb_valid_o), 64'(0));
        chk("rst_ready", 64'(src_ready_o), 64'hf);
        chk("rst_overflow", 64'(overflow_o), 64'(0));
        rst_n = 1'b1;
        sq[2] = 5;
        step(4'b0100, 1'b0);
        chk("lat_early", 64'(cdb_valid_o), 64'(0));
        step(4'b0000, 1'b0);
        chk("lat_valid0", 64'(cdb_valid_o[0]), 64'(1));
        chk("lat_rob5", 64'(cdb_reg_id_o[0]), 64'(5));
        chk("lat_valid1", 64'(cdb_valid_o[1]), 64'(0));

        // fairness: all four push every cycle for 8 cycles
        step(4'b0000, 1'b1);
        for (int s = 0; s < 4; s++) bc[s] = 0;
        for (int c = 0; c < 8; c++) begin
            step(4'b1111, 1'b0);
            if (c >= 1) begin
                chk("fair_rot_p0", 64'(cdb_info_o[0].w_data[17:16]), 64'((c % 2 == 1) ? 0 : 2));
                chk("fair_rot_p1", 64'(cdb_info_o[1].w_data[17:16]), 64'((c % 2 == 1) ? 1 : 3));
            end
        end
        mx = bc[0];
        mn = bc[0];
        for (int s = 1; s < 4; s++) begin
            if (bc[s] > mx) mx = bc[s];
            if (bc[s] < mn) mn = bc[s];
        end
        chk("fair_spread", 64'(mx - mn <= 1), 64'(1));
        chk("fair_min", 64'(mn >= 3), 64'(1));

        // backpressure: every producer obeys ready with one extra result in flight
        step(4'b0000, 1'b1);
        for (int s = 0; s < 4; s++) begin
            bc[s] = 0;
            pushed[s] = 0;
        end
        r_prev = 4'hf;
        seen_low = 1'b0;
        for (int c = 0; c < 30; c++) begin
            v = r_prev;
            r_prev = src_ready_o;
            for (int s = 0; s < 4; s++) if (v[s]) pushed[s]++;
            step(v, 1'b0);
            chk("bp_no_overflow", 64'(overflow_o), 64'(0));
            if (src_ready_o[0] === 1'b0) seen_low = 1'b1;
        end
        for (int c = 0; c < 10; c++) step(4'b0000, 1'b0);
        chk("bp_ready0_fell", 64'(seen_low), 64'(1));
        for (int s = 0; s < 4; s++) chk("bp_all_broadcast", 64'(bc[s]), 64'(pushed[s]));

        // pointer wrap: source 3 alone, 10 sequential rob_ids
        step(4'b0000, 1'b1);
        sq[3] = 0;
        exp_wrap = 0;
        for (int c = 0; c < 12; c++) begin
            step((c < 10) ? 4'b1000 : 4'b0000, 1'b0);
            chk("wrap_gap", 64'(cdb_valid_o[0]), 64'(c >= 1 && c <= 10));
            chk("wrap_p1_idle", 64'(cdb_valid_o[1]), 64'(0));
            if (cdb_valid_o[0] === 1'b1) begin
                chk("wrap_id", 64'(cdb_reg_id_o[0]), 64'(exp_wrap));
                exp_wrap++;
            end
        end
        chk("wrap_total", 64'(exp_wrap), 64'(10));

        // full FIFO: push accepted when popping, dropped when not
        step(4'b0000, 1'b1);
        done_acc = 1'b0;
        done_drop = 1'b0;
        for (int c = 0; c < 40 && !done_drop; c++) begin
            g = m_grants();
            v = 4'b0010;
            for (int s = 0; s < 4; s++) if (s != 1 && mq[s].size() < 3) v[s] = 1'b1;
            if (mq[1].size() == 4 && g[1] && !done_acc) begin
                step(v, 1'b0);
                chk("full_acc_overflow", 64'(overflow_o), 64'(0));
                chk("full_acc_ready", 64'(src_ready_o[1]), 64'(0));
                done_acc = 1'b1;
            end else if (mq[1].size() == 4 && !g[1] && done_acc) begin
                step(v, 1'b0);
                chk("full_drop_overflow", 64'(overflow_o), 64'(1));
                done_drop = 1'b1;
            end else begin
                step(v, 1'b0);
            end
        end
        chk("full_acc_seen", 64'(done_acc), 64'(1));
        chk("full_drop_seen", 64'(done_drop), 64'(1));

        // flush mid-stream with concurrent pushes
        step(4'b0000, 1'b1);
        for (int c = 0; c < 4; c++) step(4'b1111, 1'b0);
        step(4'b1111, 1'b1);
        for (int s = 0; s < 4; s++) mark[s] = sq[s];
        stale = 0;
        chk("flush_valid", 64'(cdb_valid_o), 64'(0));
        chk("flush_ready", 64'(src_ready_o), 64'hf);
        chk("flush_overflow", 64'(overflow_o), 64'(0));
        step(4'b0101, 1'b0);
        for (int c = 0; c < 6; c++) step(4'b0000, 1'b0);
        chk("flush_no_stale", 64'(stale), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Collects execution results from all issue-queue/execute pipes (ALU, MUL/DIV, LSU, branch), buffers each source in a small private FIFO and broadcasts up to CDB_COUNT results per cycle on the common data bus. The bus feeds the IQs' `cdb_*_i` forwarding ports and the ROB writeback. Each source's `ready` drives that IQ's `fifo_ready`. Fair round-robin arbitration prevents a busy ALU from starving long-latency units.

## Interface
Parameters:
- SRC_COUNT, 4, number of producing execute pipes
- CDB_COUNT, 2, number of CDB broadcast ports
- FIFO_DEPTH, 4, entries per source FIFO (power of two, ≥ SKID+1)
- SKID, 2, entries reserved for results already in flight in a producer's 2-stage pipe

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- flush  in  1  pipeline flush, synchronous, same effect as reset on state
- src_valid_i  in  [SRC_COUNT]  result valid (producer's `excute_valid_o`)
- src_data_i  in  cdb_info_t[SRC_COUNT]  result payload (producer's `result_o`)
- src_ready_o  out  [SRC_COUNT]  FIFO can absorb SKID more results; registered
- cdb_info_o  out  cdb_info_t[CDB_COUNT]  broadcast payload, registered
- cdb_data_o  out  word_t[CDB_COUNT]  = cdb_info_o[k].w_data
- cdb_reg_id_o  out  rob_id_t[CDB_COUNT]  = cdb_info_o[k].rob_id
- cdb_valid_o  out  [CDB_COUNT]  broadcast valid, registered
- overflow_o  out  1  sticky: a push hit a full FIFO

## Operation
- Per source i: circular FIFO, rd/wr pointers of $clog2(FIFO_DEPTH) bits wrapping modulo depth, count of $clog2(FIFO_DEPTH)+1 bits.
- Push: src_valid_i[i] writes at wr_ptr regardless of src_ready_o. If count==FIFO_DEPTH and no pop that cycle, the entry is dropped, pointers are unchanged, and overflow_o is set.
- Push and pop in the same cycle on the same FIFO: count unchanged. A push into a full FIFO that pops that cycle is accepted.
- Arbitration is combinational over FIFO heads as of the current cycle; entries written this cycle are not eligible.
- Scan order starts at rr_ptr and wraps modulo SRC_COUNT. The first CDB_COUNT non-empty sources are granted, at most one entry per source per cycle. Grant n goes to port n, so port 0 is the first in scan order.
- Granted FIFOs pop. If any grant: rr_ptr <= (index of last granted source + 1) mod SRC_COUNT. With no grant, rr_ptr holds.
- Output registers load each cycle: granted ports get valid=1 and head payload; ungranted ports get valid=0 and payload '0.
- src_ready_o[i] <= (count_next[i] <= FIFO_DEPTH − SKID), where count_next is post-push/pop.
- The CDB has no backpressure. Every broadcast is consumed.
- Reset/flush: all counts and pointers 0, rr_ptr 0, cdb_valid_o 0, cdb_info_o '0, src_ready_o all 1, overflow_o 0. Pushes in a flush cycle are discarded and produce no broadcast after flush.

## Timing
- Latency: src_valid_i sampled at edge t → FIFO head at cycle t+1 → cdb_valid_o high at cycle t+2 (no bypass).
- Throughput: CDB_COUNT results per cycle total, at most 1 per source per cycle.
- src_ready_o reflects state after edge t during cycle t+1. A producer may still deliver up to SKID results after ready falls; these must fit.
- overflow_o is set the cycle after the offending push and holds until reset/flush.
- Flush mid-stream: cycle after flush, cdb_valid_o=0 on all ports and all FIFOs are empty.

## Test plan
- Reset: hold rst_n=0 two cycles → cdb_valid_o=0, src_ready_o=4'b1111, overflow_o=0. Single push src 2, rob_id=5 → cdb_valid_o[0]=1, cdb_reg_id_o[0]=5 exactly two cycles later, port 1 invalid.
- Fairness: all 4 sources push one entry each every cycle for 8 cycles → grants rotate {0,1},{2,3},{0,1}…. Per-source broadcast counts differ by ≤1. No source is skipped.
- Backpressure: source 0 pushes every cycle while other 3 also stream → src_ready_o[0] falls when count exceeds 2. Producer honouring ready with 2-cycle in-flight never sets overflow_o. Every pushed rob_id is broadcast exactly once, in push order per source.
- Full + simultaneous pop: fill source 1 to 4 entries, then push while it is granted → push accepted, count stays 4, overflow_o=0. Push while not granted → entry dropped, overflow_o=1 next cycle.
- Pointer wrap: push 10 sequential rob_ids (0..9) into source 3 alone at rate matching drain → broadcast order 0..9 on port 0, no gaps, rr_ptr returns to 0 after each grant.
- Flush mid-operation: 3 entries queued in each FIFO, assert flush with concurrent pushes → next cycle cdb_valid_o=0, src_ready_o all 1. No pre-flush rob_id ever appears afterward.
